word_token_classifier: RTL and testbench



---
 rtl/word_token_classifier_pkg.sv | 28 ++
 rtl/word_token_classifier_ascii_lower.sv | 15 +
 rtl/word_token_classifier.sv | 81 ++++++++
 tb/tb_word_token_classifier.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/word_token_classifier_pkg.sv
// Shared constants, FSM state encoding and token codes for the word token classifier
// and the downstream block-nesting checker.
package word_token_classifier_pkg;

  localparam logic [7:0] ASCII_SPACE       = 8'h20;
  localparam logic [7:0] ASCII_NUL         = 8'h00;
  localparam logic [7:0] ASCII_UPPER_A     = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z     = 8'h5A;
  localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_B     = 4'd1,
    S_BE    = 4'd2,
    S_BEG   = 4'd3,
    S_BEGI  = 4'd4,
    S_BEGIN = 4'd5,
    S_E     = 4'd6,
    S_EN    = 4'd7,
    S_END   = 4'd8,
    S_OTHER = 4'd9
  } state_t;

  localparam logic [1:0] TOK_OTHER = 2'd0;
  localparam logic [1:0] TOK_BEGIN = 2'd1;
  localparam logic [1:0] TOK_END   = 2'd2;

endpackage

// File: rtl/word_token_classifier_ascii_lower.sv
// Combinational fold of 'A'..'Z' to lowercase; every other byte passes unchanged.
module ascii_lower
  import word_token_classifier_pkg::*;
(
  input  logic [7:0] ch,
  output logic [7:0] lower
);

  always_comb begin
    lower = ch;
    if (ch >= ASCII_UPPER_A && ch <= ASCII_UPPER_Z)
      lower = ch + ASCII_CASE_OFFSET;
  end

endmodule

// File: rtl/word_token_classifier.sv
// Splits an ASCII stream into space-delimited words and emits one registered
// BEGIN/END/OTHER token pulse per completed word.
module word_token_classifier
  import word_token_classifier_pkg::*;
#(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  output logic             tok_valid,
  output logic             tok_begin,
  output logic             tok_end,
  output logic [LEN_W-1:0] word_len,
  output logic [CNT_W-1:0] word_cnt
);

  state_t           state, state_next;
  logic [LEN_W-1:0] len, len_next;
  logic [7:0]       lc;
  logic             done;

  ascii_lower u_lower (
    .ch    (in),
    .lower (lc)
  );

  always_comb begin
    state_next = state;
    len_next   = len;
    done       = 1'b0;
    if (in == ASCII_NUL) begin
      state_next = state;
    end else if (in == ASCII_SPACE) begin
      done       = (state != S_IDLE);
      state_next = S_IDLE;
      len_next   = '0;
    end else begin
      len_next = (len == '1) ? len : len + LEN_W'(1);
      // Any character not continuing a keyword prefix, or following a full keyword, falls to OTHER
      state_next = S_OTHER;
      unique case (state)
        S_IDLE: begin
          if (lc == "b")      state_next = S_B;
          else if (lc == "e") state_next = S_E;
        end
        S_B:    if (lc == "e") state_next = S_BE;
        S_BE:   if (lc == "g") state_next = S_BEG;
        S_BEG:  if (lc == "i") state_next = S_BEGI;
        S_BEGI: if (lc == "n") state_next = S_BEGIN;
        S_E:    if (lc == "n") state_next = S_EN;
        S_EN:   if (lc == "d") state_next = S_END;
        default: state_next = S_OTHER;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      len       <= '0;
      tok_valid <= 1'b0;
      tok_begin <= 1'b0;
      tok_end   <= 1'b0;
      word_len  <= '0;
      word_cnt  <= '0;
    end else begin
      state     <= state_next;
      len       <= len_next;
      tok_valid <= done;
      tok_begin <= done && (state == S_BEGIN);
      tok_end   <= done && (state == S_END);
      if (done) begin
        word_len <= len;
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_word_token_classifier.sv
// Directed self-checking bench for word_token_classifier.
module tb_word_token_classifier;

  logic       clk;
  logic       reset;
  logic [7:0] in;
  logic       tok_valid;
  logic       tok_begin;
  logic       tok_end;
  logic [3:0] word_len;
  logic [7:0] word_cnt;

  int n_checks;
  int n_fail;

  int         np;
  logic       p_b   [16];
  logic       p_e   [16];
  logic [3:0] p_len [16];
  logic [7:0] last_cnt;

  word_token_classifier #(.LEN_W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .tok_valid (tok_valid),
    .tok_begin (tok_begin),
    .tok_end   (tok_end),
    .word_len  (word_len),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [7:0] c);
    in = c;
    @(posedge clk);
    #1;
    if (tok_valid === 1'b1) begin
      if (np < 16) begin
        p_b[np]   = tok_begin;
        p_e[np]   = tok_end;
        p_len[np] = word_len;
      end
      last_cnt = word_cnt;
      np++;
    end
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) step(s[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(8'h00);
    step(8'h00);
    reset = 1'b0;
    np = 0;
    last_cnt = '0;
  endtask

  task automatic test_reset();
    do_reset();
    step(8'h00);
    n_checks++;
    if ({tok_valid, tok_begin, tok_end, word_len, word_cnt} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b b=%b e=%b len=%0d cnt=%0d want all 0",
               tok_valid, tok_begin, tok_end, word_len, word_cnt);
    end
    n_checks++;
    if (np !== 0) begin
      n_fail++;
      $display("FAIL reset_no_pulse: got %0d pulses want 0", np);
    end
  endtask

  task automatic test_hello();
    do_reset();
    send("Hello w");
    n_checks++;
    if (np !== 1 || p_b[0] !== 1'b0 || p_e[0] !== 1'b0 || p_len[0] !== 4'd5 || last_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL hello_token: got np=%0d b=%b e=%b len=%0d cnt=%0d want np=1 b=0 e=0 len=5 cnt=1",
               np, p_b[0], p_e[0], p_len[0], last_cnt);
    end
    step(8'h20);
    n_checks++;
    if (np !== 2 || p_len[1] !== 4'd1 || last_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL hello_w_token: got np=%0d len=%0d cnt=%0d want np=2 len=1 cnt=2",
               np, p_len[1], last_cnt);
    end
  endtask

  task automatic test_begin_end();
    do_reset();
    send("beGIn eNd ");
    n_checks++;
    if (np !== 2) begin
      n_fail++;
      $display("FAIL be_pulses: got %0d want 2", np);
    end
    n_checks++;
    if (p_b[0] !== 1'b1 || p_e[0] !== 1'b0 || p_len[0] !== 4'd5) begin
      n_fail++;
      $display("FAIL be_begin_token: got b=%b e=%b len=%0d want b=1 e=0 len=5", p_b[0], p_e[0], p_len[0]);
    end
    n_checks++;
    if (p_b[1] !== 1'b0 || p_e[1] !== 1'b1 || p_len[1] !== 4'd3 || last_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL be_end_token: got b=%b e=%b len=%0d cnt=%0d want b=0 e=1 len=3 cnt=2",
               p_b[1], p_e[1], p_len[1], last_cnt);
    end
  endtask

  task automatic test_other();
    do_reset();
    send("beginn  Endd ");
    n_checks++;
    if (np !== 2) begin
      n_fail++;
      $display("FAIL other_pulses: got %0d want 2", np);
    end
    n_checks++;
    if (p_b[0] !== 1'b0 || p_e[0] !== 1'b0 || p_len[0] !== 4'd6) begin
      n_fail++;
      $display("FAIL other_beginn: got b=%b e=%b len=%0d want b=0 e=0 len=6", p_b[0], p_e[0], p_len[0]);
    end
    n_checks++;
    if (p_b[1] !== 1'b0 || p_e[1] !== 1'b0 || p_len[1] !== 4'd4 || last_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL other_endd: got b=%b e=%b len=%0d cnt=%0d want b=0 e=0 len=4 cnt=2",
               p_b[1], p_e[1], p_len[1], last_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 20; i++) step("x");
    step(8'h20);
    n_checks++;
    if (np !== 1 || p_len[0] !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_len20: got np=%0d len=%0d want np=1 len=15", np, p_len[0]);
    end
    for (int i = 0; i < 14; i++) step("y");
    step(8'h20);
    n_checks++;
    if (np !== 2 || p_len[1] !== 4'd14) begin
      n_fail++;
      $display("FAIL sat_len14: got np=%0d len=%0d want np=2 len=14", np, p_len[1]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) send("a ");
    n_checks++;
    if (word_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL wrap_255: got %0d want 255", word_cnt);
    end
    send("a ");
    n_checks++;
    if (np !== 256 || word_cnt !== 8'd0 || tok_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_zero: got np=%0d cnt=%0d v=%b want np=256 cnt=0 v=1", np, word_cnt, tok_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send("beg");
    reset = 1'b1;
    step("x");
    reset = 1'b0;
    n_checks++;
    if (tok_valid !== 1'b0 || word_cnt !== 8'd0 || word_len !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got v=%b cnt=%0d len=%0d want 0 0 0", tok_valid, word_cnt, word_len);
    end
    send("in ");
    n_checks++;
    if (np !== 1 || p_b[0] !== 1'b0 || p_e[0] !== 1'b0 || p_len[0] !== 4'd2 || last_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL mid_reset_token: got np=%0d b=%b e=%b len=%0d cnt=%0d want np=1 b=0 e=0 len=2 cnt=1",
               np, p_b[0], p_e[0], p_len[0], last_cnt);
    end
  endtask

  task automatic test_nul_and_hold();
    do_reset();
    step("B"); step(8'h00); step("E"); step(8'h00); step("g"); step("i"); step("N");
    step(8'h20);
    n_checks++;
    if (np !== 1 || p_b[0] !== 1'b1 || p_len[0] !== 4'd5) begin
      n_fail++;
      $display("FAIL nul_begin: got np=%0d b=%b len=%0d want np=1 b=1 len=5", np, p_b[0], p_len[0]);
    end
    step(8'h00);
    n_checks++;
    if (tok_valid !== 1'b0 || tok_begin !== 1'b0 || word_len !== 4'd5 || word_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL hold_after_pulse: got v=%b b=%b len=%0d cnt=%0d want v=0 b=0 len=5 cnt=1",
               tok_valid, tok_begin, word_len, word_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send("e end");
    step(8'h20);
    n_checks++;
    if (np !== 2 || p_len[0] !== 4'd1 || p_e[0] !== 1'b0 || tok_end !== 1'b1 || word_len !== 4'd3) begin
      n_fail++;
      $display("FAIL b2b_tokens: got np=%0d len0=%0d e0=%b e=%b len=%0d want np=2 len0=1 e0=0 e=1 len=3",
               np, p_len[0], p_e[0], tok_end, word_len);
    end
    step(8'h20);
    n_checks++;
    if (tok_valid !== 1'b0 || tok_end !== 1'b0 || np !== 2) begin
      n_fail++;
      $display("FAIL b2b_space_idle: got v=%b e=%b np=%0d want v=0 e=0 np=2", tok_valid, tok_end, np);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    np       = 0;
    last_cnt = '0;
    reset    = 1'b1;
    in       = 8'h00;
    test_reset();
    test_hello();
    test_begin_end();
    test_other();
    test_saturate();
    test_wrap();
    test_reset_mid();
    test_nul_and_hold();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
